// File: rtl/psum_acc_sram_if.sv
// rtl/psum_acc_sram_if.sv - request/data bundle for the psum accumulate buffer
interface psum_acc_sram_if #(
  parameter int aw = 11,
  parameter int bw = 128
);
  logic          CEN;
  logic          REN;
  logic          WEN;
  logic          ACC;
  logic [aw-1:0] A_rd;
  logic [aw-1:0] A_wr;
  logic [bw-1:0] D;
  logic [bw-1:0] Q;
  logic          ovf;

  modport master (
    output CEN, REN, WEN, ACC, A_rd, A_wr, D,
    input  Q, ovf
  );

  modport slave (
    input  CEN, REN, WEN, ACC, A_rd, A_wr, D,
    output Q, ovf
  );
endinterface

// File: rtl/psum_acc_sram.sv
// rtl/psum_acc_sram.sv - 1R1W psum buffer with lane-wise accumulate, forwarding, saturation
module psum_acc_sram #(
  parameter int num     = 2048,
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int SAT     = 1
) (
  input  logic            CLK,
  input  logic            reset,
  psum_acc_sram_if.slave  bus
);
  localparam int aw = $clog2(num);
  localparam int bw = col * psum_bw;
  localparam logic [psum_bw-1:0] lane_max = {1'b0, {(psum_bw-1){1'b1}}};
  localparam logic [psum_bw-1:0] lane_min = {1'b1, {(psum_bw-1){1'b0}}};

  logic [bw-1:0] mem [num];

  // one-entry write stage: a write issued on edge T commits on edge T+1
  logic          wv;
  logic [aw-1:0] wa;
  logic [bw-1:0] wd;
  logic          wacc;

  logic          issue_wr;
  logic          issue_rd;
  logic [bw-1:0] old_word;
  logic [bw-1:0] commit_word;
  logic          any_ovf;
  logic [psum_bw:0] lane_sum [col];

  assign issue_wr = !bus.CEN && !bus.WEN;
  assign issue_rd = !bus.CEN && !bus.REN;
  assign old_word = mem[wa];

  // value being committed this edge: plain data, or per-lane sum with optional clamp
  always_comb begin
    commit_word = wd;
    any_ovf     = 1'b0;
    lane_sum    = '{default: '0};
    if (wacc) begin
      for (int i = 0; i < col; i++) begin
        lane_sum[i] = {old_word[(i+1)*psum_bw-1], old_word[i*psum_bw +: psum_bw]}
                    + {wd[(i+1)*psum_bw-1], wd[i*psum_bw +: psum_bw]};
        // the two top bits disagree only when the true sum left the lane's signed range
        if (lane_sum[i][psum_bw] != lane_sum[i][psum_bw-1]) begin
          any_ovf = 1'b1;
          if (SAT != 0)
            commit_word[i*psum_bw +: psum_bw] = lane_sum[i][psum_bw] ? lane_min : lane_max;
          else
            commit_word[i*psum_bw +: psum_bw] = lane_sum[i][psum_bw-1:0];
        end else begin
          commit_word[i*psum_bw +: psum_bw] = lane_sum[i][psum_bw-1:0];
        end
      end
    end
  end

  // capture new writes; reset drops any pending write
  always_ff @(posedge CLK) begin
    if (reset) begin
      wv <= 1'b0;
    end else begin
      wv <= issue_wr;
      if (issue_wr) begin
        wa   <= bus.A_wr;
        wd   <= bus.D;
        wacc <= bus.ACC;
      end
    end
  end

  // commit the staged write; the array itself is never cleared
  always_ff @(posedge CLK) begin
    if (!reset && wv)
      mem[wa] <= commit_word;
  end

  // registered read with write-first forwarding of the committing word, plus overflow pulse
  always_ff @(posedge CLK) begin
    if (reset) begin
      bus.Q   <= '0;
      bus.ovf <= 1'b0;
    end else begin
      bus.ovf <= wv && wacc && any_ovf;
      if (issue_rd)
        bus.Q <= (wv && (wa == bus.A_rd)) ? commit_word : mem[bus.A_rd];
    end
  end
endmodule
